vga_framebuffer_arbiter: RTL and testbench
==========================================

Name: vga_framebuffer_arbiter

Overview:
Shares one single-port, double-buffered pixel RAM between VGA scan-out and a pixel writer (e.g. the genetic image generator).
- Display reads always win on pixel-tick cycles; the writer gets every remaining cycle.
- Front/back buffer swap is deferred to the frame boundary so scan-out never tears.
- Sits between the VGA timing controller (line/column/active/frameStart) and the framebuffer RAM.

Parameters:
Width, 640, visible pixels per line
Height, 480, visible lines per frame
PixelWidth, 8, bits per pixel
ReadLatency, 1, RAM read latency in cycles (>=1)
LineWidth, $clog2(Height), line index width
ColumnWidth, $clog2(Width), column index width
PixelAddressWidth, $clog2(Width*Height), per-buffer address width

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
pixelTick  in  1  one-cycle strobe per VGA pixel period
displayActive  in  1  timing controller is in visible region
line  in  LineWidth  current visible line
column  in  ColumnWidth  current visible column
frameStart  in  1  one-cycle pulse at start of vertical blanking
swapRequest  in  1  pulse: writer finished back buffer
swapDone  out  1  pulse: swap applied
writeValid  in  1  writer has a pixel
writeReady  out  1  writer pixel accepted this cycle
writeAddress  in  PixelAddressWidth  line*Width+column in back buffer
writeData  in  PixelWidth  pixel value
writeDropped  out  1  pulse: accepted write was out of range
memAddress  out  PixelAddressWidth+1  {buffer select, pixel address}
memWriteEnable  out  1  RAM write strobe
memWriteData  out  PixelWidth  RAM write data
memReadData  in  PixelWidth  RAM read data, ReadLatency after address
pixel  out  PixelWidth  pixel to DAC, 0 when not valid
pixelValid  out  1  pixel holds fetched data

Behaviour:
- Reset: displayBuffer=0, swap FSM=IDLE, read pipeline cleared. Outputs swapDone=0, writeDropped=0, pixel=0, pixelValid=0, memWriteEnable=0.
- displayRead = pixelTick & displayActive & line<Height & column<Width.
- Out-of-range line/column is treated as inactive: no read, pixelValid=0.
- Arbitration (combinational per cycle):
  - displayRead=1: memAddress={displayBuffer, line*Width+column}, memWriteEnable=0, writeReady=0.
  - Otherwise, if writeValid and FSM=IDLE: writeReady=1.
  - Otherwise writeReady=0.
- writeReady never depends on writeValid's timing beyond that same cycle; it is asserted only when writeValid=1.
- Write acceptance (writeValid & writeReady), in the same cycle:
  - writeAddress<Width*Height: memWriteEnable=1, memAddress={~displayBuffer, writeAddress}, memWriteData=writeData.
  - writeAddress>=Width*Height: no RAM write; writeDropped pulses in the next cycle.
- Address arithmetic: line*Width+column is computed at PixelAddressWidth bits, unsigned, with no truncation inside the valid range.
- Read pipeline:
  - A valid-bit shift register of depth ReadLatency tags each display read.
  - When the tag exits at cycle T+ReadLatency, memReadData is registered into pixel with pixelValid=1, visible at T+ReadLatency+1.
  - Untagged slots register pixel=0, pixelValid=0.
  - Latency is fixed and independent of writer traffic.
- Swap FSM:
  - IDLE: swapRequest -> PENDING.
  - PENDING: writeReady forced 0 (back buffer frozen). swapRequest ignored.
  - PENDING with frameStart: toggle displayBuffer, go to IDLE, swapDone=1 in the next cycle.
  - swapRequest and frameStart together in IDLE: go to PENDING only. The swap waits for the next frameStart.
  - frameStart in IDLE: no effect.
- In-flight reads during a swap use the buffer captured at issue; the toggle affects only subsequent reads.
- Reset mid-operation: pending swap lost, in-flight reads discarded, displayBuffer=0.

Decomposition:
- Shared package vga_pkg: timing/geometry constants (Width, Height, borders), the swap state enum {SWAP_IDLE, SWAP_PENDING}, and a pixel_address function (line*Width+column).
- One sub-module: vga_read_pipeline, a ReadLatency-deep valid shift register plus output pixel register, with clear on rst.

Test Plan:
- Reset: hold rst 2 cycles with writeValid=1 -> writeReady=0, memWriteEnable=0, pixelValid=0, pixel=0, swapDone=0.
- Display read, ReadLatency=1, displayBuffer=0: pixelTick at line=2, column=5 -> memAddress=0x00505 (1285), memReadData=0xA5 next cycle, pixel=0xA5 with pixelValid=1 two cycles after the tick.
- Conflict: writeValid=1, writeAddress=10 on a pixelTick cycle while active -> writeReady=0. Next cycle, no tick -> writeReady=1, memWriteEnable=1, memAddress MSB=1, low bits=10.
- Swap: swapRequest, writer offered data for 100 cycles -> writeReady=0 throughout. frameStart -> swapDone pulses 1 cycle later, reads use MSB=1, writes use MSB=0.
- Coincidence: swapRequest and frameStart in the same cycle -> no swap. Next frameStart -> swap plus swapDone.
- Out-of-range: writeAddress=307200 accepted -> no memWriteEnable, writeDropped=1 next cycle. Active pixel with column=640 -> no read, pixelValid=0.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : Geometry/timing constants, swap state and pixel address helper
//            shared by the framebuffer arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Visible geometry and 640x480@60 border/porch timing.
  localparam int c_WIDTH               = 640;
  localparam int c_HEIGHT              = 480;
  localparam int c_H_FRONT_PORCH       = 16;
  localparam int c_H_SYNC              = 96;
  localparam int c_H_BACK_PORCH        = 48;
  localparam int c_V_FRONT_PORCH       = 10;
  localparam int c_V_SYNC              = 2;
  localparam int c_V_BACK_PORCH        = 33;

  localparam int c_PIXEL_WIDTH         = 8;
  localparam int c_READ_LATENCY        = 1;
  localparam int c_LINE_WIDTH          = $clog2(c_HEIGHT);
  localparam int c_COLUMN_WIDTH        = $clog2(c_WIDTH);
  localparam int c_PIXEL_ADDRESS_WIDTH = $clog2(c_WIDTH * c_HEIGHT);

  typedef enum logic [0:0] {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_t;

  // Row-major address; 32-bit unsigned so no truncation inside the visible range.
  function automatic int unsigned pixel_address(
    input int unsigned line,
    input int unsigned column,
    input int unsigned width
  );
    return line * width + column;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_framebuffer_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_framebuffer_arbiter_if
// Purpose  : Timing, writer, swap and RAM signals of the framebuffer arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_framebuffer_arbiter_if #(
  parameter int WIDTH       = vga_pkg::c_WIDTH,
  parameter int HEIGHT      = vga_pkg::c_HEIGHT,
  parameter int PIXEL_WIDTH = vga_pkg::c_PIXEL_WIDTH
);
  import vga_pkg::*;

  localparam int c_LINE_W = $clog2(HEIGHT);
  localparam int c_COL_W  = $clog2(WIDTH);
  localparam int c_ADDR_W = $clog2(WIDTH * HEIGHT);

  logic                   pixelTick;
  logic                   displayActive;
  logic [c_LINE_W-1:0]    line;
  logic [c_COL_W-1:0]     column;
  logic                   frameStart;
  logic                   swapRequest;
  logic                   swapDone;
  logic                   writeValid;
  logic                   writeReady;
  logic [c_ADDR_W-1:0]    writeAddress;
  logic [PIXEL_WIDTH-1:0] writeData;
  logic                   writeDropped;
  logic [c_ADDR_W:0]      memAddress;
  logic                   memWriteEnable;
  logic [PIXEL_WIDTH-1:0] memWriteData;
  logic [PIXEL_WIDTH-1:0] memReadData;
  logic [PIXEL_WIDTH-1:0] pixel;
  logic                   pixelValid;

  // Arbiter side.
  modport slave (
    input  pixelTick, displayActive, line, column, frameStart, swapRequest,
           writeValid, writeAddress, writeData, memReadData,
    output swapDone, writeReady, writeDropped, memAddress, memWriteEnable,
           memWriteData, pixel, pixelValid
  );

  // Timing controller / writer / RAM side.
  modport master (
    output pixelTick, displayActive, line, column, frameStart, swapRequest,
           writeValid, writeAddress, writeData, memReadData,
    input  swapDone, writeReady, writeDropped, memAddress, memWriteEnable,
           memWriteData, pixel, pixelValid
  );

endinterface
`default_nettype wire

// File: rtl/vga_read_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : vga_read_pipeline
// Purpose  : Tags display reads through the RAM latency and registers the
//            returned pixel (zero when the slot carried no read).
// Revision : 1.0 - initial release
// ============================================================================
module vga_read_pipeline #(
  parameter int PIXEL_WIDTH  = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_read,
  input  logic [PIXEL_WIDTH-1:0] i_mem_data,
  output logic [PIXEL_WIDTH-1:0] o_pixel,
  output logic                   o_pixel_valid
);

  logic [READ_LATENCY-1:0] r_tag;

  generate
    if (READ_LATENCY == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (rst) r_tag <= '0;
        else     r_tag <= i_read;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (rst) r_tag <= '0;
        else     r_tag <= {r_tag[READ_LATENCY-2:0], i_read};
      end
    end
  endgenerate

  // Tag exits exactly when the RAM presents the data for that read.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_pixel       <= '0;
      o_pixel_valid <= 1'b0;
    end else begin
      o_pixel_valid <= r_tag[READ_LATENCY-1];
      o_pixel       <= r_tag[READ_LATENCY-1] ? i_mem_data : '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_framebuffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_framebuffer_arbiter
// Purpose  : Shares a single-port double-buffered pixel RAM between scan-out
//            (priority) and a writer, with tear-free frame-boundary swaps.
// Revision : 1.0 - initial release
// ============================================================================
module vga_framebuffer_arbiter
  import vga_pkg::*;
#(
  parameter int WIDTH        = c_WIDTH,
  parameter int HEIGHT       = c_HEIGHT,
  parameter int PIXEL_WIDTH  = c_PIXEL_WIDTH,
  parameter int READ_LATENCY = c_READ_LATENCY
) (
  input  logic                     clk,
  input  logic                     rst,
  vga_framebuffer_arbiter_if.slave bus
);

  localparam int c_ADDR_W = $clog2(WIDTH * HEIGHT);

  swap_state_t         r_state;
  swap_state_t         w_state_next;
  logic                w_toggle;
  logic                r_display_buffer;
  logic                r_swap_done;
  logic                r_write_dropped;
  logic                w_display_read;
  logic                w_write_ready;
  logic                w_write_accept;
  logic                w_write_in_range;
  logic [c_ADDR_W-1:0] w_display_address;

  // Out-of-range coordinates behave exactly like blanking.
  assign w_display_read = bus.pixelTick & bus.displayActive &
                          (int'(bus.line) < HEIGHT) & (int'(bus.column) < WIDTH);

  assign w_display_address = c_ADDR_W'(pixel_address(32'(bus.line), 32'(bus.column), WIDTH));
  assign w_write_in_range  = 32'(bus.writeAddress) < 32'(WIDTH * HEIGHT);

  // Back buffer is frozen while a swap is pending.
  assign w_write_ready  = ~rst & ~w_display_read & bus.writeValid & (r_state == SWAP_IDLE);
  assign w_write_accept = bus.writeValid & w_write_ready;

  assign bus.writeReady     = w_write_ready;
  assign bus.memWriteEnable = w_write_accept & w_write_in_range;
  assign bus.memWriteData   = bus.writeData;
  assign bus.memAddress     = w_display_read ? {r_display_buffer, w_display_address}
                                             : {~r_display_buffer, bus.writeAddress};
  assign bus.swapDone       = r_swap_done;
  assign bus.writeDropped   = r_write_dropped;

  always_comb begin
    w_state_next = r_state;
    w_toggle     = 1'b0;
    case (r_state)
      SWAP_IDLE: begin
        if (bus.swapRequest) w_state_next = SWAP_PENDING;
      end
      SWAP_PENDING: begin
        if (bus.frameStart) begin
          w_state_next = SWAP_IDLE;
          w_toggle     = 1'b1;
        end
      end
      default: w_state_next = SWAP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= SWAP_IDLE;
      r_display_buffer <= 1'b0;
      r_swap_done      <= 1'b0;
      r_write_dropped  <= 1'b0;
    end else begin
      r_state          <= w_state_next;
      r_display_buffer <= r_display_buffer ^ w_toggle;
      r_swap_done      <= w_toggle;
      r_write_dropped  <= w_write_accept & ~w_write_in_range;
    end
  end

  vga_read_pipeline #(
    .PIXEL_WIDTH  (PIXEL_WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_read_pipeline (
    .clk           (clk),
    .rst           (rst),
    .i_read        (w_display_read),
    .i_mem_data    (bus.memReadData),
    .o_pixel       (bus.pixel),
    .o_pixel_valid (bus.pixelValid)
  );

endmodule
`default_nettype wire

// File: tb/tb_vga_framebuffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_framebuffer_arbiter
// Purpose  : Directed and randomized checks of the framebuffer arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_framebuffer_arbiter;
  import vga_pkg::*;

  localparam int c_RL   = c_READ_LATENCY;
  localparam int c_AW   = c_PIXEL_ADDRESS_WIDTH + 1;
  localparam int c_AREA = c_WIDTH * c_HEIGHT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  logic            r_override_en  = 1'b0;
  logic [7:0]      r_override_val = 8'h00;
  logic [c_AW-1:0] r_addr_pipe [c_RL];

  vga_framebuffer_arbiter_if bus ();

  vga_framebuffer_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Read-only RAM stand-in: contents are a fixed hash of the address.
  function automatic logic [7:0] ram_f(input logic [c_AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]} ^ 8'h3C;
  endfunction

  always @(posedge clk) begin
    r_addr_pipe[0] <= bus.memAddress;
    for (int i = 1; i < c_RL; i++) r_addr_pipe[i] <= r_addr_pipe[i-1];
  end

  assign bus.memReadData = r_override_en ? r_override_val : ram_f(r_addr_pipe[c_RL-1]);

  task automatic set_idle();
    bus.pixelTick     = 1'b0;
    bus.displayActive = 1'b0;
    bus.line          = '0;
    bus.column        = '0;
    bus.frameStart    = 1'b0;
    bus.swapRequest   = 1'b0;
    bus.writeValid    = 1'b0;
    bus.writeAddress  = '0;
    bus.writeData     = '0;
  endtask

  task automatic set_read(input int l, input int c);
    bus.pixelTick     = 1'b1;
    bus.displayActive = 1'b1;
    bus.line          = 9'(l);
    bus.column        = 10'(c);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    bus.writeValid   = 1'b1;
    bus.writeAddress = 19'd5;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_assert++; if (bus.writeReady !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", bus.writeReady); end
    n_assert++; if (bus.memWriteEnable !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", bus.memWriteEnable); end
    n_assert++; if (bus.pixelValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.pixelValid); end
    n_assert++; if (bus.pixel !== 8'h00) begin n_fail++; $display("FAIL reset_pixel got %h want 00", bus.pixel); end
    n_assert++; if (bus.swapDone !== 1'b0) begin n_fail++; $display("FAIL reset_swapdone got %b want 0", bus.swapDone); end
    n_assert++; if (bus.writeDropped !== 1'b0) begin n_fail++; $display("FAIL reset_dropped got %b want 0", bus.writeDropped); end
    @(negedge clk);
    rst = 1'b0;
    set_idle();
    @(negedge clk);
  endtask

  task automatic test_display_read();
    r_override_en  = 1'b1;
    r_override_val = 8'hA5;
    set_read(2, 5);
    #1;
    n_assert++; if (bus.memAddress !== 20'd1285) begin n_fail++; $display("FAIL read_addr got %h want %h", bus.memAddress, 20'd1285); end
    n_assert++; if (bus.memWriteEnable !== 1'b0) begin n_fail++; $display("FAIL read_we got %b want 0", bus.memWriteEnable); end
    @(negedge clk);
    set_idle();
    #1;
    n_assert++; if (bus.pixelValid !== 1'b0) begin n_fail++; $display("FAIL read_early_valid got %b want 0", bus.pixelValid); end
    @(negedge clk);
    #1;
    n_assert++; if (bus.pixelValid !== 1'b1 || bus.pixel !== 8'hA5) begin n_fail++; $display("FAIL read_pixel got %b/%h want 1/a5", bus.pixelValid, bus.pixel); end
    @(negedge clk);
    r_override_en = 1'b0;
    #1;
    n_assert++; if (bus.pixelValid !== 1'b0 || bus.pixel !== 8'h00) begin n_fail++; $display("FAIL read_after got %b/%h want 0/00", bus.pixelValid, bus.pixel); end
  endtask

  task automatic test_conflict();
    set_read(0, 0);
    bus.writeValid   = 1'b1;
    bus.writeAddress = 19'd10;
    bus.writeData    = 8'h5A;
    #1;
    n_assert++; if (bus.writeReady !== 1'b0 || bus.memWriteEnable !== 1'b0) begin n_fail++; $display("FAIL conflict_block got ready=%b we=%b want 0/0", bus.writeReady, bus.memWriteEnable); end
    @(negedge clk);
    bus.pixelTick = 1'b0;
    #1;
    n_assert++; if (bus.writeReady !== 1'b1 || bus.memWriteEnable !== 1'b1) begin n_fail++; $display("FAIL conflict_accept got ready=%b we=%b want 1/1", bus.writeReady, bus.memWriteEnable); end
    n_assert++; if (bus.memAddress !== {1'b1, 19'd10} || bus.memWriteData !== 8'h5A) begin n_fail++; $display("FAIL conflict_addr got %h/%h want %h/5a", bus.memAddress, bus.memWriteData, {1'b1, 19'd10}); end
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_swap();
    bus.swapRequest = 1'b1;
    @(negedge clk);
    bus.swapRequest = 1'b0;
    for (int i = 0; i < 100; i++) begin
      bus.writeValid   = 1'b1;
      bus.writeAddress = 19'($urandom_range(0, c_AREA - 1));
      #1;
      n_assert++; if (bus.writeReady !== 1'b0 || bus.memWriteEnable !== 1'b0) begin n_fail++; $display("FAIL swap_frozen cycle %0d got ready=%b we=%b want 0/0", i, bus.writeReady, bus.memWriteEnable); end
      @(negedge clk);
    end
    set_idle();
    bus.frameStart = 1'b1;
    @(negedge clk);
    bus.frameStart = 1'b0;
    set_read(1, 1);
    #1;
    n_assert++; if (bus.swapDone !== 1'b1) begin n_fail++; $display("FAIL swap_done got %b want 1", bus.swapDone); end
    n_assert++; if (bus.memAddress !== {1'b1, 19'd641}) begin n_fail++; $display("FAIL swap_read_addr got %h want %h", bus.memAddress, {1'b1, 19'd641}); end
    @(negedge clk);
    set_idle();
    bus.writeValid   = 1'b1;
    bus.writeAddress = 19'd77;
    #1;
    n_assert++; if (bus.swapDone !== 1'b0) begin n_fail++; $display("FAIL swap_done_pulse got %b want 0", bus.swapDone); end
    n_assert++; if (bus.writeReady !== 1'b1 || bus.memWriteEnable !== 1'b1 || bus.memAddress !== {1'b0, 19'd77}) begin n_fail++; $display("FAIL swap_write got ready=%b we=%b addr=%h want 1/1/%h", bus.writeReady, bus.memWriteEnable, bus.memAddress, {1'b0, 19'd77}); end
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_coincidence();
    bus.swapRequest = 1'b1;
    bus.frameStart  = 1'b1;
    @(negedge clk);
    set_idle();
    set_read(2, 5);
    #1;
    n_assert++; if (bus.swapDone !== 1'b0) begin n_fail++; $display("FAIL coinc_no_done got %b want 0", bus.swapDone); end
    n_assert++; if (bus.memAddress !== {1'b1, 19'd1285}) begin n_fail++; $display("FAIL coinc_no_swap got %h want %h", bus.memAddress, {1'b1, 19'd1285}); end
    @(negedge clk);
    set_idle();
    repeat (3) @(negedge clk);
    bus.frameStart = 1'b1;
    @(negedge clk);
    bus.frameStart = 1'b0;
    set_read(2, 5);
    #1;
    n_assert++; if (bus.swapDone !== 1'b1) begin n_fail++; $display("FAIL coinc_done got %b want 1", bus.swapDone); end
    n_assert++; if (bus.memAddress !== {1'b0, 19'd1285}) begin n_fail++; $display("FAIL coinc_swapped got %h want %h", bus.memAddress, {1'b0, 19'd1285}); end
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_out_of_range();
    bus.writeValid   = 1'b1;
    bus.writeAddress = 19'(c_AREA);
    #1;
    n_assert++; if (bus.writeReady !== 1'b1 || bus.memWriteEnable !== 1'b0) begin n_fail++; $display("FAIL oor_write got ready=%b we=%b want 1/0", bus.writeReady, bus.memWriteEnable); end
    @(negedge clk);
    set_idle();
    set_read(3, 640);
    #1;
    n_assert++; if (bus.writeDropped !== 1'b1) begin n_fail++; $display("FAIL oor_dropped got %b want 1", bus.writeDropped); end
    n_assert++; if (bus.memWriteEnable !== 1'b0) begin n_fail++; $display("FAIL oor_col_we got %b want 0", bus.memWriteEnable); end
    @(negedge clk);
    set_read(480, 0);
    bus.writeValid   = 1'b1;
    bus.writeAddress = 19'd9;
    #1;
    n_assert++; if (bus.writeDropped !== 1'b0) begin n_fail++; $display("FAIL oor_dropped_pulse got %b want 0", bus.writeDropped); end
    n_assert++; if (bus.writeReady !== 1'b1 || bus.memWriteEnable !== 1'b1 || bus.memAddress !== {1'b1, 19'd9}) begin n_fail++; $display("FAIL oor_line_write got ready=%b we=%b addr=%h", bus.writeReady, bus.memWriteEnable, bus.memAddress); end
    @(negedge clk);
    set_idle();
    #1;
    n_assert++; if (bus.pixelValid !== 1'b0 || bus.pixel !== 8'h00) begin n_fail++; $display("FAIL oor_col_pixel got %b/%h want 0/00", bus.pixelValid, bus.pixel); end
    @(negedge clk);
    #1;
    n_assert++; if (bus.pixelValid !== 1'b0 || bus.pixel !== 8'h00) begin n_fail++; $display("FAIL oor_line_pixel got %b/%h want 0/00", bus.pixelValid, bus.pixel); end
    @(negedge clk);
  endtask

  task automatic test_random(input int n_cycles);
    logic            m_buf;
    logic            m_pending;
    logic            exp_sd;
    logic            exp_dr;
    logic [8:0]      exp_pix [$];
    logic [8:0]      e;
    logic [c_AW-1:0] exp_addr;
    logic            rd;
    logic            ready;
    logic            inr;
    logic            do_rst;
    int              l;
    int              c;

    rst = 1'b1;
    set_idle();
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b0;
    m_buf     = 1'b0;
    m_pending = 1'b0;
    exp_sd    = 1'b0;
    exp_dr    = 1'b0;
    for (int i = 0; i < c_RL + 1; i++) exp_pix.push_back(9'h000);

    for (int cyc = 0; cyc < n_cycles; cyc++) begin
      e = exp_pix.pop_front();
      n_assert++; if (bus.pixelValid !== e[8] || bus.pixel !== e[7:0]) begin n_fail++; $display("FAIL rand_pixel cycle %0d got %b/%h want %b/%h", cyc, bus.pixelValid, bus.pixel, e[8], e[7:0]); end
      n_assert++; if (bus.swapDone !== exp_sd) begin n_fail++; $display("FAIL rand_swapdone cycle %0d got %b want %b", cyc, bus.swapDone, exp_sd); end
      n_assert++; if (bus.writeDropped !== exp_dr) begin n_fail++; $display("FAIL rand_dropped cycle %0d got %b want %b", cyc, bus.writeDropped, exp_dr); end

      do_rst            = ($urandom_range(0, 299) == 0);
      l                 = $urandom_range(0, 490);
      c                 = $urandom_range(0, 660);
      rst               = do_rst;
      bus.pixelTick     = 1'($urandom_range(0, 1));
      bus.displayActive = ($urandom_range(0, 4) != 0);
      bus.line          = 9'(l);
      bus.column        = 10'(c);
      bus.frameStart    = ($urandom_range(0, 19) == 0);
      bus.swapRequest   = ($urandom_range(0, 9) == 0);
      bus.writeValid    = ($urandom_range(0, 9) < 7);
      bus.writeAddress  = ($urandom_range(0, 9) == 0) ? 19'($urandom_range(c_AREA, 524287))
                                                       : 19'($urandom_range(0, c_AREA - 1));
      bus.writeData     = 8'($urandom);
      #1;

      rd  = bus.pixelTick && bus.displayActive && (l < c_HEIGHT) && (c < c_WIDTH);
      inr = int'(bus.writeAddress) < c_AREA;

      if (do_rst) begin
        n_assert++; if (bus.writeReady !== 1'b0 || bus.memWriteEnable !== 1'b0) begin n_fail++; $display("FAIL rand_rst_write cycle %0d got ready=%b we=%b want 0/0", cyc, bus.writeReady, bus.memWriteEnable); end
        m_buf     = 1'b0;
        m_pending = 1'b0;
        exp_sd    = 1'b0;
        exp_dr    = 1'b0;
        exp_pix.delete();
        for (int i = 0; i < c_RL + 1; i++) exp_pix.push_back(9'h000);
      end else begin
        ready = !rd && bus.writeValid && !m_pending;
        n_assert++; if (bus.writeReady !== ready) begin n_fail++; $display("FAIL rand_ready cycle %0d got %b want %b", cyc, bus.writeReady, ready); end
        if (rd) begin
          exp_addr = {m_buf, c_PIXEL_ADDRESS_WIDTH'(l * c_WIDTH + c)};
          n_assert++; if (bus.memAddress !== exp_addr || bus.memWriteEnable !== 1'b0) begin n_fail++; $display("FAIL rand_read cycle %0d got addr=%h we=%b want %h/0", cyc, bus.memAddress, bus.memWriteEnable, exp_addr); end
          exp_pix.push_back({1'b1, ram_f(exp_addr)});
        end else begin
          exp_pix.push_back(9'h000);
          if (ready && inr) begin
            exp_addr = {~m_buf, bus.writeAddress};
            n_assert++; if (bus.memWriteEnable !== 1'b1 || bus.memAddress !== exp_addr || bus.memWriteData !== bus.writeData) begin n_fail++; $display("FAIL rand_write cycle %0d got we=%b addr=%h want 1/%h", cyc, bus.memWriteEnable, bus.memAddress, exp_addr); end
          end else begin
            n_assert++; if (bus.memWriteEnable !== 1'b0) begin n_fail++; $display("FAIL rand_no_write cycle %0d got %b want 0", cyc, bus.memWriteEnable); end
          end
        end
        exp_dr = ready && !inr;
        exp_sd = m_pending && bus.frameStart;
        if (m_pending && bus.frameStart) begin
          m_buf     = ~m_buf;
          m_pending = 1'b0;
        end else if (!m_pending && bus.swapRequest) begin
          m_pending = 1'b1;
        end
      end
      @(negedge clk);
    end
    rst = 1'b0;
    set_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    test_reset();
    test_display_read();
    test_conflict();
    test_swap();
    test_coincidence();
    test_out_of_range();
    test_random(3000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
